// File: rtl/regfile_wb_if.sv
// Decoder/datapath-facing bus of the register file: operand addresses, write-back
// controls and data in; operand reads and write-back observability out.
interface regfile_wb_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic              regdest;
  logic              memtoreg;
  logic              regwrite;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_commit;

  // Datapath side: drives decoder fields and results, consumes operands.
  modport master (
    output rs, rt, rd, regdest, memtoreg, regwrite, alu_result, mem_rdata,
    input  rdata1, rdata2, wb_addr, wb_data, wb_commit
  );

  // Register file side.
  modport slave (
    input  rs, rt, rd, regdest, memtoreg, regwrite, alu_result, mem_rdata,
    output rdata1, rdata2, wb_addr, wb_data, wb_commit
  );
endinterface

// File: rtl/regfile_wb.sv
// MIPS-lite architectural register file with write-back destination/data selection.
// Two combinational read ports, one write port committed on the rising clock edge.
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input logic         clk,
  input logic         rst_n,
  regfile_wb_if.slave bus
);
  localparam int AW = 5;

  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wr_en;
  logic              commit;
  logic [DATA_W-1:0] regs [NREG];

  assign wb_addr = bus.regdest  ? bus.rd        : bus.rt;
  assign wb_data = bus.memtoreg ? bus.mem_rdata : bus.alu_result;

  // regwrite gates everything, so unknown select inputs cannot reach the storage enables.
  assign wr_en = bus.regwrite && (wb_addr != '0);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] value;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            value <= '0;
          end else if (wr_en && (wb_addr == AW'(gi))) begin
            value <= wb_data;
          end
        end

        assign regs[gi] = value;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit <= 1'b0;
    end else begin
      commit <= wr_en;
    end
  end

  // No write-through bypass: reads see the old value until the edge.
  assign bus.rdata1    = regs[bus.rs];
  assign bus.rdata2    = regs[bus.rt];
  assign bus.wb_addr   = wb_addr;
  assign bus.wb_data   = wb_data;
  assign bus.wb_commit = commit;
endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: stimulus queues expectations, a monitor pops and
// compares them against the DUT outputs whenever a sample point is announced.
module tb_regfile_wb;
  localparam int S_RD1 = 0, S_RD2 = 1, S_COMMIT = 2, S_WADDR = 3, S_WDATA = 4;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } item_t;

  logic clk;
  logic rst_n;
  regfile_wb_if #(.DATA_W(32)) bus ();

  regfile_wb #(.DATA_W(32), .NREG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  item_t q[$];
  event  chk_ev;
  int    checks = 0;
  int    errors = 0;

  task automatic expect_val(input string name, input int sig, input logic [31:0] exp);
    item_t it;
    it.name = name;
    it.sig  = sig;
    it.exp  = exp;
    q.push_back(it);
  endtask

  task automatic sample();
    ->chk_ev;
    #1;
  endtask

  // Monitor: compares every queued expectation at the announced sample point.
  initial begin
    item_t       it;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        it = q.pop_front();
        case (it.sig)
          S_RD1:    act = bus.rdata1;
          S_RD2:    act = bus.rdata2;
          S_COMMIT: act = {31'd0, bus.wb_commit};
          S_WADDR:  act = {27'd0, bus.wb_addr};
          default:  act = bus.wb_data;
        endcase
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end else begin
          $display("ok   %s: %h", it.name, act);
        end
      end
    end
  end

  task automatic drive(input logic we, input logic rdst, input logic m2r,
                       input logic [4:0] d, input logic [4:0] t,
                       input logic [31:0] alu, input logic [31:0] mem);
    bus.regwrite   = we;
    bus.regdest    = rdst;
    bus.memtoreg   = m2r;
    bus.rd         = d;
    bus.rt         = t;
    bus.alu_result = alu;
    bus.mem_rdata  = mem;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rs = 5'd0;
    drive(1'b0, 1'b1, 1'b1, 5'd7, 5'd0, 32'h0, 32'h55);
    #12;
    // Under reset: reads are zero, write-back selects still follow inputs.
    bus.rs = 5'd5;
    #1;
    expect_val("reset rdata1 r5", S_RD1, 32'h0);
    expect_val("reset rdata2 r0", S_RD2, 32'h0);
    expect_val("reset wb_commit", S_COMMIT, 32'h0);
    expect_val("reset wb_addr follows rd", S_WADDR, 32'd7);
    expect_val("reset wb_data follows mem", S_WDATA, 32'h55);
    sample();

    // Release mid-cycle, then load r1..r31.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'(i), 5'd0, 32'hA000_0000 | 32'(i), 32'h0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    for (int i = 1; i < 32; i += 10) begin
      bus.rs = 5'(i);
      bus.rt = 5'(32 - i);
      #1;
      expect_val($sformatf("load r%0d port1", i), S_RD1, 32'hA000_0000 | 32'(i));
      expect_val($sformatf("load r%0d port2", 32 - i), S_RD2, 32'hA000_0000 | 32'(32 - i));
      sample();
    end

    // One more write so wb_commit is high, then reset mid-cycle.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd31, 5'd0, 32'hA000_001F, 32'h0);
    post_edge();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    expect_val("commit before reset", S_COMMIT, 32'h1);
    sample();
    #1;
    rst_n = 1'b0;
    bus.rs = 5'd31;
    bus.rt = 5'd20;
    #1;
    expect_val("async reset r31", S_RD1, 32'h0);
    expect_val("async reset r20", S_RD2, 32'h0);
    expect_val("async reset wb_commit", S_COMMIT, 32'h0);
    sample();

    // Write pending while reset held: reset wins.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 32'h44, 32'h0);
    bus.rs = 5'd4;
    post_edge();
    expect_val("reset wins r4", S_RD1, 32'h0);
    expect_val("reset wins wb_commit", S_COMMIT, 32'h0);
    sample();

    // Write presented in the release cycle commits at the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 32'h2222, 32'h0);
    bus.rs = 5'd2;
    post_edge();
    expect_val("release-cycle write r2", S_RD1, 32'h2222);
    expect_val("release-cycle commit", S_COMMIT, 32'h1);
    sample();

    // Seed r9 so its preservation is visible.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 32'h99, 32'h0);
    post_edge();

    // R-type write to rd=8, rt=9 must stay intact.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd9, 32'h0000_1234, 32'h0BAD_0BAD);
    bus.rs = 5'd8;
    #1;
    expect_val("rtype wb_addr", S_WADDR, 32'd8);
    expect_val("rtype wb_data", S_WDATA, 32'h1234);
    expect_val("rtype r8 before edge", S_RD1, 32'h0);
    sample();
    post_edge();
    expect_val("rtype r8 after edge", S_RD1, 32'h1234);
    expect_val("rtype r9 unchanged", S_RD2, 32'h99);
    expect_val("rtype wb_commit", S_COMMIT, 32'h1);
    sample();

    // lw: destination rt, data from memory.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 5'd8, 5'd17, 32'h4, 32'hDEAD_BEEF);
    #1;
    expect_val("lw wb_addr", S_WADDR, 32'd17);
    expect_val("lw wb_data", S_WDATA, 32'hDEAD_BEEF);
    sample();
    post_edge();
    expect_val("lw r17", S_RD2, 32'hDEAD_BEEF);
    expect_val("lw r8 untouched", S_RD1, 32'h1234);
    sample();

    // $zero write is discarded.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    bus.rs = 5'd0;
    post_edge();
    expect_val("zero r0 read", S_RD1, 32'h0);
    expect_val("zero wb_commit", S_COMMIT, 32'h0);
    sample();

    // Write disabled: r5 keeps its value.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 32'h55, 32'h0);
    post_edge();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 32'hAAAA_AAAA, 32'h0);
    bus.rs = 5'd5;
    post_edge();
    expect_val("disabled r5 kept", S_RD1, 32'h55);
    expect_val("disabled wb_commit", S_COMMIT, 32'h0);
    sample();

    // Read-during-write on r3 via both ports.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 32'h11, 32'h0);
    bus.rs = 5'd3;
    post_edge();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 32'h22, 32'h0);
    #1;
    expect_val("rdw port1 old", S_RD1, 32'h11);
    expect_val("rdw port2 old", S_RD2, 32'h11);
    sample();
    post_edge();
    expect_val("rdw port1 new", S_RD1, 32'h22);
    expect_val("rdw port2 new", S_RD2, 32'h22);
    sample();

    // Back-to-back writes to r3.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 32'h33, 32'h0);
    post_edge();
    expect_val("b2b first r3", S_RD1, 32'h33);
    sample();
    drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 32'h44, 32'h0);
    post_edge();
    expect_val("b2b final r3", S_RD1, 32'h44);
    expect_val("b2b final port2", S_RD2, 32'h44);
    sample();

    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    #5;
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
